// File: rtl/smem_pkg.sv
// Shared types for the simple-memory request/response path: FSM encoding,
// request/response bundles, and the byte-offset helper.
package smem_pkg;

    localparam int SMEM_ADDR_W = 32;
    localparam int SMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic                       we;
        logic [SMEM_ADDR_W-1:0]     addr;
        logic [SMEM_DATA_W-1:0]     wdata;
        logic [SMEM_DATA_W/8-1:0]   wstrb;
    } mem_req_t;

    typedef struct packed {
        logic [SMEM_DATA_W-1:0]     rdata;
        logic                       err;
    } mem_rsp_t;

    // Number of low address bits that select a byte within one data word.
    function automatic int byte_off_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/smem_ram_array.sv
// Word storage for the RAM target: per-byte write enables, synchronous
// write, combinational read. Contents are deliberately not reset.
module smem_ram_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk_i,
    input  logic                           we_i,
    input  logic [DATA_W/8-1:0]            be_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [DATA_W-1:0]              wdata_i,
    output logic [DATA_W-1:0]              rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/smem_target_ram.sv
// End-of-chain RAM responder: one outstanding request, byte-strobed writes,
// fixed programmable response latency, misaligned/out-of-range error flag.
module smem_target_ram
    import smem_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH_WORDS = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                LATENCY     = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_wstrb_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic [1:0]          dbg_state_o
);

    // Handshake: a beat moves on any cycle where valid and ready are both high;
    // a response, once valid, holds valid/rdata/err until rsp_ready_i is seen.
    localparam int             STRB_W = DATA_W / 8;
    localparam int             OFF_W  = byte_off_bits(DATA_W);
    localparam int             IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] SPAN  = (ADDR_W + 1)'(DEPTH_WORDS * STRB_W);
    localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + SPAN;
    localparam logic [3:0]     LAT    = 4'(LATENCY);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_RESP = RESP;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept;
    logic              misaligned;
    logic              out_of_range;
    logic              req_err;
    logic              ram_we;
    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  word_idx;
    logic [DATA_W-1:0] ram_rdata;

    assign req_ready_o  = (state_q == S_IDLE) && !rst_i;
    assign accept       = req_valid_i && req_ready_o;
    assign misaligned   = |req_addr_i[OFF_W-1:0];
    // Range test is done one bit wider so a window at the top of the map does not wrap.
    assign out_of_range = ({1'b0, req_addr_i} < {1'b0, BASE_ADDR}) ||
                          ({1'b0, req_addr_i} >= LIMIT);
    assign req_err      = misaligned || out_of_range;
    assign offset       = req_addr_i - BASE_ADDR;
    assign word_idx     = IDX_W'(offset >> OFF_W);
    assign ram_we       = accept && req_we_i && !req_err;

    smem_ram_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .be_i    (req_wstrb_i),
        .addr_i  (word_idx),
        .wdata_i (req_wdata_i),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Read data is taken at the accept edge, before any later write.
                    rsp_err_d   = req_err;
                    rsp_rdata_d = (req_we_i || req_err) ? '0 : ram_rdata;
                    if (LAT == 4'd0) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_smem_target_ram.sv
// Directed bench for smem_target_ram: one instance at LATENCY=2 for the main
// traffic, a second at LATENCY=5 for the reset-while-waiting case.
module tb_smem_target_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=2 instance
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  dbg_state;

    // LATENCY=5 instance
    logic        b_rst;
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_wstrb;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic [1:0]  b_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];

    smem_target_ram #(.LATENCY(2)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .dbg_state_o(dbg_state)
    );

    smem_target_ram #(.LATENCY(5)) u_dut5 (
        .clk_i(clk), .rst_i(b_rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_wstrb_i(b_req_wstrb),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
        .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err), .dbg_state_o(b_dbg_state)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request and return just after the accepting edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic exp_err, input logic [31:0] exp_rdata);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check_eq("req_ready_timeout", req_ready, 1);
        exp_q.push_back({exp_err, exp_rdata});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Wait for the response, check latency and payload against the scoreboard.
    task automatic collect(input string tag, input int hold);
        int n;
        logic [32:0] exp;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 60);
        check_eq({tag, "_lat"}, n, 3);
        check_eq({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h0;
        check_eq({tag, "_err"}, rsp_err, exp[32]);
        check_eq({tag, "_rdata"}, rsp_rdata, exp[31:0]);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (i == 1) begin
                    // Stray write while busy must be ignored.
                    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
                    req_wdata = 32'h0; req_wstrb = 4'hF;
                end
                check_eq({tag, "_hold_valid"}, rsp_valid, 1);
                check_eq({tag, "_hold_rdata"}, rsp_rdata, exp[31:0]);
                check_eq({tag, "_hold_ready"}, req_ready, 0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            check_eq({tag, "_release_valid"}, rsp_valid, 0);
            check_eq({tag, "_release_ready"}, req_ready, 1);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        int seen;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
        b_rst = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0;
        b_req_wdata = '0; b_req_wstrb = '0; b_rsp_ready = 1'b1;

        // Reset and idle
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_ready", req_ready, 0);
            check_eq("rst_valid", rsp_valid, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", req_ready, 1);
        check_eq("idle_state", dbg_state, 0);
        check_eq("idle_valid", rsp_valid, 0);
        check_eq("idle_rdata", rsp_rdata, 0);
        check_eq("idle_err", rsp_err, 0);

        // Write then read
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        collect("wr10", 0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
        collect("rd10", 0);

        // Partial strobe
        issue(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0);
        collect("wr20", 0);
        issue(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0);
        collect("wr20_strb5", 0);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h11BB33DD);
        collect("rd20", 0);

        // Errors: no write, zero data
        issue(1'b0, 32'h22, 32'h0, 4'h0, 1'b1, 32'h0);
        collect("rd22_mis", 0);
        issue(1'b0, 32'h400, 32'h0, 4'h0, 1'b1, 32'h0);
        collect("rd400_oor", 0);
        issue(1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
        collect("wr22_mis", 0);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h11BB33DD);
        collect("rd20_after_err", 0);
        issue(1'b1, 32'h0, 32'h01020304, 4'hF, 1'b0, 32'h0);
        collect("wr00", 0);
        issue(1'b1, 32'h400, 32'h99999999, 4'hF, 1'b1, 32'h0);
        collect("wr400_oor", 0);
        issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h01020304);
        collect("rd00", 0);

        // Zero strobe write and top word
        issue(1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0);
        collect("wr10_strb0", 0);
        issue(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
        collect("wr3fc", 0);
        issue(1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D);
        collect("rd3fc", 0);
        issue(1'b0, 32'h3FD, 32'h0, 4'h0, 1'b1, 32'h0);
        collect("rd3fd_mis", 0);

        // Response backpressure (stray write during hold must not land)
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
        collect("bp_rd10", 5);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
        collect("rd10_after_bp", 0);

        // LATENCY=5 instance: write, then reset while waiting on a read
        @(negedge clk);
        b_rst = 1'b0;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h8;
        b_req_wdata = 32'h55AA55AA; b_req_wstrb = 4'hF;
        check_eq("b_wr_ready", b_req_ready, 1);
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_rsp_valid && n < 40);
        check_eq("b_wr_lat", n, 6);
        check_eq("b_wr_err", b_rsp_err, 0);
        @(posedge clk);
        #1;

        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h8; b_req_wstrb = 4'h0;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        seen = 0;
        @(negedge clk);
        seen += int'(b_rsp_valid);
        @(posedge clk);
        #1;
        b_rst = 1'b1;
        @(negedge clk);
        seen += int'(b_rsp_valid);
        check_eq("b_rst_ready", b_req_ready, 0);
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        @(negedge clk);
        check_eq("b_post_rst_state", b_dbg_state, 0);
        check_eq("b_post_rst_ready", b_req_ready, 1);
        for (int i = 0; i < 10; i++) begin
            seen += int'(b_rsp_valid);
            @(negedge clk);
        end
        check_eq("b_no_rsp_after_rst", seen, 0);

        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h8;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_rsp_valid && n < 40);
        check_eq("b_rd_lat", n, 6);
        check_eq("b_rd_rdata", b_rsp_rdata, 32'h55AA55AA);
        check_eq("b_rd_err", b_rsp_err, 0);
        @(posedge clk);
        #1;

        check_eq("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/smem_target_ram.md
Name: smem_target_ram

Overview:
- Word-addressed RAM target on the simple-memory request/response side, directly downstream of the AXI4-Lite slave adapter.
- Consumes one request at a time, applies byte-strobed writes, returns read data after a programmable latency, and flags misaligned or out-of-range accesses.
- Acts as the end-of-chain responder for the adapter pair in system simulation and FPGA bring-up.

Parameters:
- ADDR_W, 32, request address width in bits.
- DATA_W, 32, data width in bits; must be 32 or 64.
- DEPTH_WORDS, 256, number of DATA_W-bit words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*DATA_W/8.
- LATENCY, 2, extra cycles between request accept and response valid; range 0..15.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  DATA_W  write data.
- req_wstrb_i  in  DATA_W/8  byte write enables.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors.
- rsp_err_o  out  1  1 = misaligned or out-of-range access.

Behaviour:
- Reset values: req_ready_o=0 during reset, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, FSM=IDLE, latency counter=0.
- RAM contents are not cleared by reset.
- In the first cycle after rst_i deasserts: IDLE and req_ready_o=1.
- Handshake: a transfer occurs on a cycle with valid & ready high.
- req_ready_o is high only in IDLE, so at most one request is outstanding.
- Once rsp_valid_o rises, rsp_valid_o, rsp_rdata_o and rsp_err_o hold stable until rsp_ready_i is sampled high.
- FSM IDLE:
  - On request accept, capture we/addr/wdata/wstrb and compute the error bit.
  - For a valid write, update the RAM at this same edge, bytes gated by wstrb.
  - If LATENCY=0, go to RESP; otherwise load the counter with LATENCY and go to WAIT.
- FSM WAIT: decrement the counter each cycle; when it reaches 1, go to RESP.
- FSM RESP: rsp_valid_o=1; on rsp_ready_i=1, go to IDLE.
- Timing: request accepted at edge T gives rsp_valid_o high in cycle T+1+LATENCY. With rsp_ready_i tied high, throughput is one request per LATENCY+2 cycles.
- Read data is the RAM word as of the accept edge, so a read returns the last completed write.
- Error rules:
  - Misaligned: req_addr_i[log2(DATA_W/8)-1:0] != 0.
  - Out-of-range: addr < BASE_ADDR or addr >= BASE_ADDR + DEPTH_WORDS*DATA_W/8. Compute the limit in ADDR_W+1 bits so it does not wrap.
  - On error: no RAM write, rsp_rdata_o=0, rsp_err_o=1. Latency is unchanged.
- Word index = (addr - BASE_ADDR) >> log2(DATA_W/8), truncated to log2(DEPTH_WORDS) bits.
- wstrb=0 on a valid write: RAM unchanged, response err=0.
- Reset mid-operation: rst_i=1 in any state forces IDLE and drops rsp_valid_o in the next cycle. The pending response is discarded. A write already applied at its accept edge remains in RAM.
- Inputs are ignored outside IDLE, so stray req_valid_i has no effect.

Decomposition:
- Package smem_pkg holds:
  - typedef state_e {IDLE, WAIT, RESP}
  - mem_req_t struct (we, addr, wdata, wstrb)
  - mem_rsp_t struct (rdata, err)
  - function byte_off_bits(DATA_W)
- The AXI adapters and the simulation drivers share these types.
- One sub-module, smem_ram_array, holds storage only: DEPTH_WORDS x DATA_W, per-byte write enable, synchronous write, combinational read.
- The FSM, counter and error check stay in smem_target_ram.

Test Plan:
- Reset then idle: rst_i high 3 cycles, low -> req_ready_o=0 while rst_i=1, req_ready_o=1 from the first cycle after, rsp_valid_o=0 throughout.
- Write then read (LATENCY=2): write addr 0x10, data 0xDEADBEEF, wstrb 0xF, then read 0x10 -> write response err=0 at T+3; read response rdata 0xDEADBEEF, err=0 at T'+3.
- Partial strobe: write 0x11223344 to 0x20, then write 0xAABBCCDD with wstrb 0x5, then read 0x20 -> 0x11BB33DD.
- Errors: read 0x22 (misaligned) and read 0x400 (out of range, DEPTH 256) -> each gives err=1, rdata=0. A following read of 0x20 still returns the prior value.
- Response backpressure: hold rsp_ready_i=0 for 5 cycles after rsp_valid_o rises -> rsp_valid_o and rsp_rdata_o stable, req_ready_o=0. Accept occurs on the first rsp_ready_i=1 cycle, and req_ready_o=1 in the next cycle.
- Reset in WAIT (LATENCY=5): accept a read, assert rst_i at T+2 -> no response ever asserted, IDLE after reset, and a subsequent read is serviced normally.
